seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Samples the active-low anode strobes and segment lines, and rejects transitions and glitches by requiring a settle time.
- Decodes each glyph back to a digit value or arrow symbol, then publishes a complete, atomically updated frame.
- Used for on-board loopback self-check and as the bench monitor for the ping-pong counter display.

---
 rtl/seg_codes_pkg.sv | 32 +++
 rtl/seg_glyph_decode.sv | 38 +++
 rtl/seg_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_codes_pkg.sv
// Shared seven-segment glyph codes (active-low, bit0=a .. bit6=g) and the
// glyph-kind encoding. The display driver and the scan decoder both import
// this package, so both sides agree on every glyph.
package seg_codes_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_UP    = 7'h5C;
  localparam logic [6:0] SEG_DOWN  = 7'h63;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_UP   = 2'd1,
    KIND_DOWN = 2'd2,
    KIND_UNK  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] val;
  } glyph_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 7-bit active-low segment pattern to
// {kind, val}. Unrecognised patterns (blank included) decode to UNK/0.
//   segs : segment lines, active-low, bit0=a .. bit6=g
//   kind : KIND_NUM / KIND_UP / KIND_DOWN / KIND_UNK
//   val  : 0-9 for numeric glyphs, 0 otherwise
module seg_glyph_decode
  import seg_codes_pkg::*;
(
  input  logic [6:0] segs,
  output logic [1:0] kind,
  output logic [3:0] val
);

  glyph_t g;

  always_comb begin
    g = '{kind: KIND_UNK, val: 4'd0};
    case (segs)
      SEG_0:    g = '{kind: KIND_NUM,  val: 4'd0};
      SEG_1:    g = '{kind: KIND_NUM,  val: 4'd1};
      SEG_2:    g = '{kind: KIND_NUM,  val: 4'd2};
      SEG_3:    g = '{kind: KIND_NUM,  val: 4'd3};
      SEG_4:    g = '{kind: KIND_NUM,  val: 4'd4};
      SEG_5:    g = '{kind: KIND_NUM,  val: 4'd5};
      SEG_6:    g = '{kind: KIND_NUM,  val: 4'd6};
      SEG_7:    g = '{kind: KIND_NUM,  val: 4'd7};
      SEG_8:    g = '{kind: KIND_NUM,  val: 4'd8};
      SEG_9:    g = '{kind: KIND_NUM,  val: 4'd9};
      SEG_UP:   g = '{kind: KIND_UP,   val: 4'd0};
      SEG_DOWN: g = '{kind: KIND_DOWN, val: 4'd0};
      default:  g = '{kind: KIND_UNK,  val: 4'd0};
    endcase
  end

  assign kind = g.kind;
  assign val  = g.val;

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed seven-segment display. Synchronises the
// anode/segment pins, waits for each dwell to settle, decodes the glyph
// into a per-slot shadow, and publishes the whole frame atomically once
// every slot has been seen.
//   clk, rst_n  : clock, async active-low reset
//   an, segs    : active-low anode strobes / segment lines
//   digit_val   : 4 bits per slot, decoded value (0 if not numeric)
//   digit_kind  : 2 bits per slot, NUM/UP/DOWN/UNK
//   num_val     : 10*slot3 + slot2 when num_ok, else 0
//   num_ok      : slots 3 and 2 both numeric
//   dir, dir_ok : arrow direction from slots 1/0 (dir holds when !dir_ok)
//   frame_valid : one-cycle pulse on each publish
//   stale       : no frame for TIMEOUT_CYCLES cycles
// Derived fields read slots 0..3, so DIGITS must be at least 4.
module seg_scan_decoder
  import seg_codes_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            segs,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [2*DIGITS-1:0]   digit_kind,
  output logic [6:0]            num_val,
  output logic                  num_ok,
  output logic                  dir,
  output logic                  dir_ok,
  output logic                  frame_valid,
  output logic                  stale
);

  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_HIT = HW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  // 2-flop synchronizer
  logic [DIGITS-1:0] an_s1_q, an_s2_q;
  logic [6:0]        segs_s1_q, segs_s2_q;

  // dwell tracking
  logic [DIGITS+6:0] prev_q, prev_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              sampled_q, sampled_d;

  // frame assembly
  logic [DIGITS-1:0]        seen_q, seen_d;
  logic [DIGITS-1:0][1:0]   sh_kind_q, sh_kind_d;
  logic [DIGITS-1:0][3:0]   sh_val_q, sh_val_d;

  // published outputs
  logic [DIGITS-1:0][1:0]   dkind_q, dkind_d;
  logic [DIGITS-1:0][3:0]   dval_q, dval_d;
  logic [6:0]               num_val_q, num_val_d;
  logic                     num_ok_q, num_ok_d;
  logic                     dir_q, dir_d;
  logic                     dir_ok_q, dir_ok_d;
  logic                     fv_q, fv_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     stale_q, stale_d;

  logic          legal, changed, sample, done;
  logic [SW-1:0] slot;
  int            nzero;
  logic [1:0]    g_kind;
  logic [3:0]    g_val;

  seg_glyph_decode u_dec (
    .segs (segs_s2_q),
    .kind (g_kind),
    .val  (g_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q   <= '0;
      an_s2_q   <= '0;
      segs_s1_q <= '0;
      segs_s2_q <= '0;
    end else begin
      an_s1_q   <= an;
      an_s2_q   <= an_s1_q;
      segs_s1_q <= segs;
      segs_s2_q <= segs_s1_q;
    end
  end

  // Legal strobe = exactly one low anode; slot is its index.
  always_comb begin
    nzero = 0;
    slot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        nzero = nzero + 1;
        slot  = SW'(i);
      end
    end
    legal = (nzero == 1);
  end

  // hold_q counts earlier consecutive edges with the same value, so the
  // value has been seen SETTLE_CYCLES times when hold_q == SETTLE_CYCLES-2
  // and the current edge still matches.
  always_comb begin
    prev_d    = {an_s2_q, segs_s2_q};
    changed   = (prev_d != prev_q);
    sample    = legal && !changed && !sampled_q && (hold_q >= HOLD_HIT);
    hold_d    = hold_q;
    sampled_d = sampled_q;
    if (!legal || changed) hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
    if (changed) sampled_d = 1'b0;
    else if (sample) sampled_d = 1'b1;
  end

  // Frame assembly. A sample on the publish edge lands in the new frame
  // because seen is cleared before the new bit is set.
  always_comb begin
    done      = &seen_q;
    seen_d    = done ? '0 : seen_q;
    sh_kind_d = sh_kind_q;
    sh_val_d  = sh_val_q;
    if (sample) begin
      seen_d[slot]    = 1'b1;
      sh_kind_d[slot] = g_kind;
      sh_val_d[slot]  = g_val;
    end
  end

  always_comb begin
    dkind_d   = dkind_q;
    dval_d    = dval_q;
    num_val_d = num_val_q;
    num_ok_d  = num_ok_q;
    dir_d     = dir_q;
    dir_ok_d  = dir_ok_q;
    fv_d      = done;
    if (done) begin
      dkind_d   = sh_kind_q;
      dval_d    = sh_val_q;
      num_ok_d  = (sh_kind_q[3] == KIND_NUM) && (sh_kind_q[2] == KIND_NUM);
      num_val_d = num_ok_d ? (7'(sh_val_q[3]) * 7'd10 + 7'(sh_val_q[2])) : 7'd0;
      dir_ok_d  = ((sh_kind_q[1] == KIND_UP)   && (sh_kind_q[0] == KIND_UP)) ||
                  ((sh_kind_q[1] == KIND_DOWN) && (sh_kind_q[0] == KIND_DOWN));
      if (dir_ok_d) dir_d = (sh_kind_q[0] == KIND_UP);
    end
    // stale follows the post-edge count so it clears with frame_valid
    if (done) tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    else tmo_d = tmo_q;
    stale_d = (tmo_d >= TMO_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      hold_q    <= '0;
      sampled_q <= 1'b0;
      seen_q    <= '0;
      sh_kind_q <= {DIGITS{KIND_UNK}};
      sh_val_q  <= '0;
      dkind_q   <= {DIGITS{KIND_UNK}};
      dval_q    <= '0;
      num_val_q <= '0;
      num_ok_q  <= 1'b0;
      dir_q     <= 1'b0;
      dir_ok_q  <= 1'b0;
      fv_q      <= 1'b0;
      tmo_q     <= '0;
      stale_q   <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      hold_q    <= hold_d;
      sampled_q <= sampled_d;
      seen_q    <= seen_d;
      sh_kind_q <= sh_kind_d;
      sh_val_q  <= sh_val_d;
      dkind_q   <= dkind_d;
      dval_q    <= dval_d;
      num_val_q <= num_val_d;
      num_ok_q  <= num_ok_d;
      dir_q     <= dir_d;
      dir_ok_q  <= dir_ok_d;
      fv_q      <= fv_d;
      tmo_q     <= tmo_d;
      stale_q   <= stale_d;
    end
  end

  assign digit_val   = dval_q;
  assign digit_kind  = dkind_q;
  assign num_val     = num_val_q;
  assign num_ok      = num_ok_q;
  assign dir         = dir_q;
  assign dir_ok      = dir_ok_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  segs = 7'h7F;
  logic [15:0] digit_val;
  logic [7:0]  digit_kind;
  logic [6:0]  num_val;
  logic        num_ok, dir, dir_ok, frame_valid, stale;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt  = 0;

  seg_scan_decoder #(
    .DIGITS(4), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .segs(segs),
    .digit_val(digit_val), .digit_kind(digit_kind),
    .num_val(num_val), .num_ok(num_ok), .dir(dir), .dir_ok(dir_ok),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    segs = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [6:0] s0, s1, s2, s3);
    dwell(4'b1110, s0, 8);
    dwell(4'b1101, s1, 8);
    dwell(4'b1011, s2, 8);
    dwell(4'b0111, s3, 8);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, k;

    // 1. reset
    an = 4'($urandom);
    segs = 7'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_kind", digit_kind, 8'hFF);
    chk("rst_fv", frame_valid, 0);
    chk("rst_stale", stale, 0);
    an = 4'hF; segs = 7'h7F;
    rst_n = 1'b1;
    base = fv_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_kind", digit_kind, 8'hFF);
    chk("idle_val", digit_val, 0);
    chk("idle_numok", num_ok, 0);
    chk("idle_nofv", fv_cnt - base, 0);

    // 2. normal frame: slots 0/1 UP, slot2=2, slot3=1
    base = fv_cnt;
    frame(7'h5C, 7'h5C, 7'h24, 7'h79);
    chk("nf_pulses", fv_cnt - base, 1);
    chk("nf_num", num_val, 12);
    chk("nf_numok", num_ok, 1);
    chk("nf_dir", dir, 1);
    chk("nf_dirok", dir_ok, 1);
    chk("nf_val", digit_val, 16'h1200);
    chk("nf_kind", digit_kind, 8'h05);
    base = fv_cnt;
    frame(7'h5C, 7'h5C, 7'h24, 7'h79);
    frame(7'h5C, 7'h5C, 7'h24, 7'h79);
    chk("nf_repeat", fv_cnt - base, 2);

    // 3. glitch rejection on slot 2
    base = fv_cnt;
    dwell(4'b1110, 7'h63, 8);
    dwell(4'b1101, 7'h63, 8);
    dwell(4'b1011, 7'h30, 3);
    dwell(4'b0111, 7'h40, 8);
    repeat (6) @(posedge clk);
    #1;
    chk("gl_nofv", fv_cnt - base, 0);
    dwell(4'b1011, 7'h30, 8);
    repeat (6) @(posedge clk);
    #1;
    chk("gl_fv", fv_cnt - base, 1);
    chk("gl_num", num_val, 3);
    chk("gl_dir", dir, 0);
    chk("gl_dirok", dir_ok, 1);
    chk("gl_val", digit_val, 16'h0300);
    chk("gl_kind", digit_kind, 8'h0A);

    // 4. illegal anodes mid-scan
    base = fv_cnt;
    dwell(4'b1110, 7'h5C, 8);
    dwell(4'b1101, 7'h5C, 8);
    dwell(4'b1100, 7'h40, 20);
    chk("il_nofv", fv_cnt - base, 0);
    dwell(4'b1011, 7'h12, 8);
    dwell(4'b0111, 7'h19, 8);
    repeat (6) @(posedge clk);
    #1;
    chk("il_fv", fv_cnt - base, 1);
    chk("il_num", num_val, 45);
    chk("il_dir", dir, 1);
    chk("il_kind", digit_kind, 8'h05);

    // 5. mixed / unknown glyphs, then 6. timeout
    base = fv_cnt;
    dwell(4'b1110, 7'h5C, 8);
    dwell(4'b1101, 7'h63, 8);
    dwell(4'b0111, 7'h7F, 8);
    an = 4'b1011; segs = 7'h30;
    k = 0;
    do begin @(negedge clk); k++; end while (frame_valid !== 1'b1 && k < 40);
    chk("mx_fv_seen", frame_valid, 1);
    an = 4'hF; segs = 7'h7F;
    k = 0;
    while (stale !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("to_cycles", k, 64);
    chk("mx_pulses", fv_cnt - base, 1);
    chk("mx_dirok", dir_ok, 0);
    chk("mx_dir_hold", dir, 1);
    chk("mx_kind", digit_kind, 8'hC9);
    chk("mx_numok", num_ok, 0);
    chk("mx_num", num_val, 0);
    @(posedge clk);
    #1;
    base = fv_cnt;
    frame(7'h5C, 7'h5C, 7'h24, 7'h79);
    chk("to_clear_fv", fv_cnt - base, 1);
    chk("to_clear", stale, 0);

    // reset mid-frame discards the partial frame
    dwell(4'b1110, 7'h5C, 8);
    dwell(4'b1101, 7'h5C, 8);
    dwell(4'b1011, 7'h24, 8);
    rst_n = 1'b0;
    an = 4'b0111; segs = 7'h79;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = fv_cnt;
    repeat (14) @(posedge clk);
    #1;
    chk("mr_nofv", fv_cnt - base, 0);
    chk("mr_kind", digit_kind, 8'hFF);
    chk("mr_numok", num_ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
